// File: rtl/vga_pattern_gen_if.sv
// Pixel bus between the VGA timing controller and the pattern generator.
// The controller sends the coordinate it will show two cycles from now, and the generator returns the pixel colour.
interface vga_pattern_gen_if;
  logic [10:0] px_h;
  logic [10:0] px_v;
  logic [11:0] px_data;

  modport master (output px_h, output px_v, input  px_data);
  modport slave  (input  px_h, input  px_v, output px_data);
endinterface

// File: rtl/vga_pattern_gen.sv
// RGB444 test-pattern source with a fixed 2-cycle latency.
// Patterns: colour bars, checkerboard, bouncing box and gradient. The pattern and box position change only at frame ticks.
module vga_pattern_gen #(
  parameter int unsigned       H_ACTIVE  = 640,
  parameter int unsigned       V_ACTIVE  = 480,
  parameter int unsigned       BOX_SIZE  = 64,
  parameter int unsigned       SPEED     = 2,
  parameter int unsigned       CHK_LOG2  = 5,
  parameter logic [11:0]       BOX_COLOR = 12'hF80
) (
  input  logic                 px_clk,
  input  logic                 rst,
  vga_pattern_gen_if.slave     px,
  input  logic [1:0]           mode_sel,
  output logic [7:0]           frame_cnt
);

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_t;

  typedef struct packed {
    logic [10:0] pos;
    logic        neg;   // 1: moving toward 0
  } axis_t;

  localparam logic [10:0] BAR_W   = 11'(H_ACTIVE / 8);
  localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_LIMIT = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP    = 11'(SPEED);
  localparam logic [10:0] BOX_W   = 11'(BOX_SIZE);

  // The box bounces off each wall and stays inside [0, limit].
  function automatic axis_t step_axis(input axis_t a, input logic [10:0] limit);
    axis_t       r;
    logic [10:0] nx;
    r  = a;
    nx = a.pos + STEP;
    if (!a.neg) begin
      if (nx >= limit) begin
        r.pos = limit;
        r.neg = 1'b1;
      end else begin
        r.pos = nx;
      end
    end else begin
      if (a.pos <= STEP) begin
        r.pos = '0;
        r.neg = 1'b0;
      end else begin
        r.pos = a.pos - STEP;
      end
    end
    return r;
  endfunction

  logic        tick;
  mode_t       mode_ff;
  axis_t       box_x, box_y;

  logic [10:0] s1_h, s1_v;
  logic        s1_active;
  mode_t       s1_mode;
  logic [11:0] colour;

  assign tick = (px.px_v == 11'(V_ACTIVE)) && (px.px_h == 11'd0);

  // Frame-rate state: the pattern, box position and frame counter change only at a tick.
  always_ff @(posedge px_clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      mode_ff   <= MODE_BARS;
      box_x     <= '{pos: '0, neg: 1'b0};
      box_y     <= '{pos: '0, neg: 1'b0};
    end else if (tick) begin
      // NOTE: non-blocking updates let every frame register see the pre-tick values of the others.
      frame_cnt <= frame_cnt + 8'd1;
      mode_ff   <= mode_t'(mode_sel);
      box_x     <= step_axis(box_x, X_LIMIT);
      box_y     <= step_axis(box_y, Y_LIMIT);
    end
  end

  always_ff @(posedge px_clk or negedge rst) begin
    if (!rst) begin
      s1_h      <= '0;
      s1_v      <= '0;
      s1_active <= 1'b0;
      s1_mode   <= MODE_BARS;
    end else begin
      s1_h      <= px.px_h;
      s1_v      <= px.px_v;
      s1_active <= (px.px_h < 11'(H_ACTIVE)) && (px.px_v < 11'(V_ACTIVE));
      s1_mode   <= mode_ff;
    end
  end

  always_comb begin
    // NOTE: default first so that no path through the case leaves colour unassigned, which would infer a latch.
    colour = 12'h000;
    unique case (s1_mode)
      MODE_BARS: begin
        case (3'(s1_h / BAR_W))
          3'd0:    colour = 12'hFFF;
          3'd1:    colour = 12'hFF0;
          3'd2:    colour = 12'h0FF;
          3'd3:    colour = 12'h0F0;
          3'd4:    colour = 12'hF0F;
          3'd5:    colour = 12'hF00;
          3'd6:    colour = 12'h00F;
          default: colour = 12'h000;
        endcase
      end
      MODE_CHECK: colour = (s1_h[CHK_LOG2] ^ s1_v[CHK_LOG2]) ? 12'h000 : 12'hFFF;
      MODE_BOX: begin
        if (s1_h >= box_x.pos && s1_h < box_x.pos + BOX_W &&
            s1_v >= box_y.pos && s1_v < box_y.pos + BOX_W)
          colour = BOX_COLOR;
      end
      MODE_GRAD: colour = {s1_h[9:6], s1_v[8:5], frame_cnt[3:0]};
      default:   colour = 12'h000;
    endcase
    if (!s1_active) colour = 12'h000;
  end

  always_ff @(posedge px_clk or negedge rst) begin
    if (!rst) px.px_data <= '0;
    else      px.px_data <= colour;
  end

endmodule
